// File: rtl/fpmul_share_ctrl.sv
// fpmul_share_ctrl: shares one single-precision floating-point multiplier between two requesters.
//
// An operand pair is accepted from one requester at a time. Arbitration is round-robin, and each
// transfer uses a valid/ready handshake. The operands are registered onto the multiplier and held
// for MUL_LATENCY cycles. The product is then captured and returned to the owning requester with a
// valid/ready response handshake. When either operand has a zero exponent field (zero or
// denormal), the multiplier is bypassed and a signed zero is returned instead.
//
// Ports:
//   clk_i, rst_n_i         clock (rising edge), asynchronous active-low reset
//   req_valid_i/ready_o    per-requester operand handshake (bit n = requester n)
//   req_a_i, req_b_i       packed operands, requester n in bits [n*32 +: 32]
//   resp_valid_o/ready_i   one-hot result handshake towards the owning requester
//   resp_data_o            shared result bus
//   mul_a_o, mul_b_o       registered operands driven to the multiplier
//   mul_p_i                product returned by the multiplier
//   busy_o                 high whenever an operation is in flight or being returned
//   op_count_o             completed responses, wrapping
module fpmul_share_ctrl #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned MUL_LATENCY = 1,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic [1:0]              req_valid_i,
  output logic [1:0]              req_ready_o,
  input  logic [2*DATA_WIDTH-1:0] req_a_i,
  input  logic [2*DATA_WIDTH-1:0] req_b_i,
  output logic [1:0]              resp_valid_o,
  input  logic [1:0]              resp_ready_i,
  output logic [DATA_WIDTH-1:0]   resp_data_o,
  output logic [DATA_WIDTH-1:0]   mul_a_o,
  output logic [DATA_WIDTH-1:0]   mul_b_o,
  input  logic [DATA_WIDTH-1:0]   mul_p_i,
  output logic                    busy_o,
  output logic [CNT_WIDTH-1:0]    op_count_o
);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e                state_q, state_d;
  logic                  ptr_q, ptr_d;
  logic                  owner_q, owner_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
  logic [DATA_WIDTH-1:0] mul_a_q, mul_a_d;
  logic [DATA_WIDTH-1:0] mul_b_q, mul_b_d;
  logic [CNT_WIDTH-1:0]  op_count_q, op_count_d;

  logic                  gnt_vld;
  logic                  gnt_idx;
  logic [DATA_WIDTH-1:0] a_sel;
  logic [DATA_WIDTH-1:0] b_sel;
  logic                  bypass;

  // Grant: a lone valid requester wins; on contention the round-robin pointer decides.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = 1'b0;
    if (state_q == StIdle) begin
      unique case (req_valid_i)
        2'b01: begin
          gnt_vld = 1'b1;
          gnt_idx = 1'b0;
        end
        2'b10: begin
          gnt_vld = 1'b1;
          gnt_idx = 1'b1;
        end
        2'b11: begin
          gnt_vld = 1'b1;
          gnt_idx = ptr_q;
        end
        default: ;
      endcase
    end
  end

  assign a_sel  = gnt_idx ? req_a_i[2*DATA_WIDTH-1:DATA_WIDTH] : req_a_i[DATA_WIDTH-1:0];
  assign b_sel  = gnt_idx ? req_b_i[2*DATA_WIDTH-1:DATA_WIDTH] : req_b_i[DATA_WIDTH-1:0];
  // The multiplier datapath cannot handle zero/denormal inputs, so these are answered locally.
  assign bypass = (a_sel[30:23] == 8'h00) || (b_sel[30:23] == 8'h00);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    resp_data_d = resp_data_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    op_count_d  = op_count_q;

    unique case (state_q)
      StIdle: begin
        if (gnt_vld) begin
          owner_d = gnt_idx;
          ptr_d   = ~gnt_idx;
          if (bypass) begin
            resp_data_d = {a_sel[DATA_WIDTH-1] ^ b_sel[DATA_WIDTH-1], {(DATA_WIDTH-1){1'b0}}};
            state_d     = StResp;
          end else begin
            mul_a_d = a_sel;
            mul_b_d = b_sel;
            cnt_d   = 4'(MUL_LATENCY);
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd1) begin
          resp_data_d = mul_p_i;
          state_d     = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        if (resp_ready_i[owner_q]) begin
          op_count_d = op_count_q + CNT_WIDTH'(1);
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= StIdle;
      ptr_q       <= 1'b0;
      owner_q     <= 1'b0;
      cnt_q       <= 4'd0;
      resp_data_q <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      op_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      resp_data_q <= resp_data_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      op_count_q  <= op_count_d;
    end
  end

  // req_ready_o is combinational from IDLE, so it is gated to stay low while reset is held.
  always_comb begin
    req_ready_o = 2'b00;
    if (gnt_vld && rst_n_i) begin
      req_ready_o = gnt_idx ? 2'b10 : 2'b01;
    end
    resp_valid_o = 2'b00;
    if (state_q == StResp) begin
      resp_valid_o = owner_q ? 2'b10 : 2'b01;
    end
  end

  assign resp_data_o = resp_data_q;
  assign mul_a_o     = mul_a_q;
  assign mul_b_o     = mul_b_q;
  assign busy_o      = (state_q != StIdle);
  assign op_count_o  = op_count_q;

endmodule
